// File: rtl/clk_div_sequencer_if.sv
// Ratio-change handshake between the system-control register path and clk_div_sequencer.
interface clk_div_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             cfg_valid;
   logic [CNT_W-1:0] cfg_div;
   logic             cfg_ready;
   logic             cfg_err;

   modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
   modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);
endinterface

// File: rtl/clk_div_sequencer.sv
// Run-controlled overflow clock divider whose ratio can be changed without runt high pulses.
// Optional status outputs cur_div / reconfig_cnt are built when DIVSEQ_STATUS_EN is defined.
module clk_div_sequencer #(
   parameter int CNT_W       = 8,
   parameter int DEFAULT_DIV = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   clk_div_sequencer_if.slave cfg,
   output logic               div_clk,
   output logic               div_tick,
   output logic               busy
`ifdef DIVSEQ_STATUS_EN
   ,
   output logic [CNT_W-1:0]   cur_div,
   output logic [7:0]         reconfig_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_LOAD  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] div_reg_q, div_reg_d;
   logic [CNT_W-1:0] new_div_q, new_div_d;
   logic             pending_q, pending_d;
   logic             div_clk_q, div_clk_d;
   logic             div_tick_q, div_tick_d;
   logic             cfg_err_q, cfg_err_d;
   logic             cfg_ready_s, xfer_s, terminal_s;

   assign cfg_ready_s = ((state_q == ST_IDLE) || (state_q == ST_RUN)) && !pending_q;
   assign xfer_s      = cfg.cfg_valid && cfg_ready_s;
   assign terminal_s  = (cnt_q == (div_reg_q - CNT_W'(1)));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pending_q) begin
               state_d = ST_LOAD;
            end else if (run) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (!run || pending_q) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (!div_clk_q) begin
               state_d = pending_q ? ST_LOAD : ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_LOAD: begin
            state_d = run ? ST_RUN : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Phase counter, request capture and ratio load.
   always_comb begin
      cnt_d      = cnt_q;
      div_reg_d  = div_reg_q;
      new_div_d  = new_div_q;
      pending_d  = pending_q;
      div_clk_d  = div_clk_q;
      div_tick_d = 1'b0;
      cfg_err_d  = xfer_s && (cfg.cfg_div == {CNT_W{1'b0}});
      if (xfer_s && (cfg.cfg_div != {CNT_W{1'b0}})) begin
         new_div_d = cfg.cfg_div;
         pending_d = 1'b1;
      end else begin
         new_div_d = new_div_q;
      end
      case (state_q)
         ST_RUN, ST_DRAIN: begin
            // Once draining with the clock low, never start another (runt) high phase.
            if ((state_q == ST_DRAIN) && !div_clk_q) begin
               cnt_d = {CNT_W{1'b0}};
            end else if (terminal_s) begin
               cnt_d      = {CNT_W{1'b0}};
               div_clk_d  = ~div_clk_q;
               div_tick_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_LOAD: begin
            div_reg_d = new_div_q;
            cnt_d     = {CNT_W{1'b0}};
            pending_d = 1'b0;
         end
         default: begin
            cnt_d     = {CNT_W{1'b0}};
            div_clk_d = 1'b0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q      <= {CNT_W{1'b0}};
         div_reg_q  <= CNT_W'(DEFAULT_DIV);
         new_div_q  <= CNT_W'(DEFAULT_DIV);
         pending_q  <= 1'b0;
         div_clk_q  <= 1'b0;
         div_tick_q <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_reg_q  <= div_reg_d;
         new_div_q  <= new_div_d;
         pending_q  <= pending_d;
         div_clk_q  <= div_clk_d;
         div_tick_q <= div_tick_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   // Output decode.
   always_comb begin
      cfg.cfg_ready = cfg_ready_s;
      cfg.cfg_err   = cfg_err_q;
      div_clk       = div_clk_q;
      div_tick      = div_tick_q;
      busy          = (state_q == ST_DRAIN) || (state_q == ST_LOAD);
   end

`ifdef DIVSEQ_STATUS_EN
   logic [7:0] reconfig_cnt_q, reconfig_cnt_d;

   // Saturating count of applied ratio changes.
   always_comb begin
      if ((state_q == ST_LOAD) && (reconfig_cnt_q != 8'd255)) begin
         reconfig_cnt_d = reconfig_cnt_q + 8'd1;
      end else begin
         reconfig_cnt_d = reconfig_cnt_q;
      end
   end

   // Status counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reconfig_cnt_q <= 8'd0;
      end else begin
         reconfig_cnt_q <= reconfig_cnt_d;
      end
   end

   assign cur_div      = div_reg_q;
   assign reconfig_cnt = reconfig_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed bench for clk_div_sequencer with a phase-length / handshake reference model.
`timescale 1ns/1ps
module tb_clk_div_sequencer;
   localparam int CNT_W       = 8;
   localparam int DEFAULT_DIV = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic run   = 1'b0;
   logic div_clk, div_tick, busy;
`ifdef DIVSEQ_STATUS_EN
   logic [CNT_W-1:0] cur_div;
   logic [7:0]       reconfig_cnt;
`endif

   clk_div_sequencer_if #(.CNT_W(CNT_W)) cfg_bus ();

   clk_div_sequencer #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .cfg      (cfg_bus),
      .div_clk  (div_clk),
      .div_tick (div_tick),
      .busy     (busy)
`ifdef DIVSEQ_STATUS_EN
      ,
      .cur_div      (cur_div),
      .reconfig_cnt (reconfig_cnt)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_ge(input string name, input int act, input int lim);
      checks++;
      if (act < lim) begin
         errors++;
         $display("FAIL %s: got %0d, expected at least %0d", name, act, lim);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out, no expected event", name);
   endtask

   // Reference model: pending request, active ratio, and phase lengths of div_clk.
   int          ratio_m, ratio_hi, pend_val, run_len;
   logic        pend_m, clk_prev, xfer_prev, zero_prev, busy_prev;
   logic        phase_valid, low_clean, busy_seen;
   logic [7:0]  div_prev;

   initial begin
      busy_seen = 1'b0;
      pend_val  = DEFAULT_DIV;
      ratio_hi  = DEFAULT_DIV;
      div_prev  = 8'd0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pend_m      = 1'b0;
            ratio_m     = DEFAULT_DIV;
            clk_prev    = 1'b0;
            xfer_prev   = 1'b0;
            zero_prev   = 1'b0;
            busy_prev   = 1'b0;
            phase_valid = 1'b0;
            low_clean   = 1'b0;
            run_len     = 0;
         end else begin
            if (xfer_prev && !zero_prev) begin
               pend_m   = 1'b1;
               pend_val = int'(div_prev);
            end
            if (busy_prev && !busy && pend_m) begin
               ratio_m = pend_val;
               pend_m  = 1'b0;
            end
            chk("cfg_ready", int'(cfg_bus.cfg_ready), int'(!busy && !pend_m));
            chk("cfg_err", int'(cfg_bus.cfg_err), int'(xfer_prev && zero_prev));
            chk("div_tick", int'(div_tick), int'(div_clk != clk_prev));
            if (busy) busy_seen = 1'b1;
            if (div_clk != clk_prev) begin
               if (phase_valid) begin
                  if (clk_prev) chk("high_phase", run_len, ratio_hi);
                  else if (low_clean) chk("low_phase", run_len, ratio_m);
                  else chk_ge("low_phase_min", run_len, ratio_m);
               end
               phase_valid = 1'b1;
               run_len     = 1;
               ratio_hi    = ratio_m;
               low_clean   = !div_clk && run && !busy;
            end else begin
               run_len++;
               if (busy || !run) low_clean = 1'b0;
            end
            xfer_prev = cfg_bus.cfg_valid && cfg_bus.cfg_ready;
            zero_prev = (cfg_bus.cfg_div == 8'd0);
            div_prev  = cfg_bus.cfg_div;
            clk_prev  = div_clk;
            busy_prev = busy;
         end
      end
   end

   task automatic wait_rise(input string name, output logic ok);
      logic p;
      ok = 1'b0;
      @(negedge clk);
      p = div_clk;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         if (div_clk && !p) begin
            ok = 1'b1;
            break;
         end
         p = div_clk;
      end
      if (!ok) timeout(name);
   endtask

   task automatic measure_period(input string name, output int hi, output int lo);
      logic ok;
      hi = 0;
      lo = 0;
      wait_rise(name, ok);
      if (ok) begin
         hi = 1;
         while (hi < 2000) begin
            @(negedge clk);
            if (!div_clk) break;
            hi++;
         end
         lo = 1;
         while (lo < 2000) begin
            @(negedge clk);
            if (div_clk) break;
            lo++;
         end
      end
   endtask

   task automatic wait_change_done(input string name);
      int n;
      n = 0;
      while (!busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) timeout(name);
   endtask

   task automatic send_cfg(input string name, input logic [7:0] d);
      @(posedge clk);
      #1;
      chk(name, int'(cfg_bus.cfg_ready), 1);
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_div   = d;
      @(posedge clk);
      #1;
      cfg_bus.cfg_valid = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  hi, lo, n, highs;
      logic ok;
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_div   = 8'd0;
      run   = 1'b1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_div_clk", int'(div_clk), 0);
      chk("rst_div_tick", int'(div_tick), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cfg_err", int'(cfg_bus.cfg_err), 0);
      chk("rst_cfg_ready", int'(cfg_bus.cfg_ready), 1);

      // 1 IDLE cycle plus 4 counted RUN cycles before the first rise
      reset = 1'b0;
      n = 0;
      while (n < 50) begin
         @(posedge clk);
         #1;
         n++;
         if (div_clk) break;
      end
      chk("first_rise_cycles", n, 5);
      measure_period("a_period", hi, lo);
      chk("a_high", hi, 4);
      chk("a_low", lo, 4);

      // Zero ratio is rejected with a one-cycle error pulse
      busy_seen = 1'b0;
      send_cfg("c_ready", 8'd0);
      chk("c_err_pulse", int'(cfg_bus.cfg_err), 1);
      @(posedge clk);
      #1;
      chk("c_err_clear", int'(cfg_bus.cfg_err), 0);
      measure_period("c_period", hi, lo);
      chk("c_high", hi, 4);
      chk("c_low", lo, 4);
      chk("c_busy_never", int'(busy_seen), 0);

      // Ratio change to 2 requested one cycle into a high phase
      wait_rise("b_rise", ok);
      send_cfg("b_ready", 8'd2);
      chk("b_ready_drop", int'(cfg_bus.cfg_ready), 0);
      @(posedge clk);
      #1;
      chk("b_busy", int'(busy), 1);
      wait_change_done("b_change");
      measure_period("b_period", hi, lo);
      chk("b_high", hi, 2);
      chk("b_low", lo, 2);

      // Stop during a high phase
      wait_rise("d_rise", ok);
      @(posedge clk);
      #1;
      run = 1'b0;
      repeat (4) @(posedge clk);
      highs = 0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk);
         #1;
         if (div_clk) highs++;
      end
      chk("d_stopped_highs", highs, 0);
      chk("d_busy", int'(busy), 0);
      chk("d_ready", int'(cfg_bus.cfg_ready), 1);

      // Reset asserted while draining
      @(posedge clk);
      #1;
      run = 1'b1;
      wait_rise("e_rise", ok);
      @(posedge clk);
      #1;
      run = 1'b0;
      @(posedge clk);
      #1;
      chk("e_in_drain", int'(busy), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("e_rst_div_clk", int'(div_clk), 0);
      chk("e_rst_div_tick", int'(div_tick), 0);
      chk("e_rst_busy", int'(busy), 0);
      chk("e_rst_cfg_err", int'(cfg_bus.cfg_err), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      run   = 1'b1;
      measure_period("e_period", hi, lo);
      chk("e_high", hi, 4);
      chk("e_low", lo, 4);

      // Extreme ratios
      send_cfg("f1_ready", 8'd1);
      wait_change_done("f1_change");
      measure_period("f1_period", hi, lo);
      chk("f1_high", hi, 1);
      chk("f1_low", lo, 1);
      send_cfg("f255_ready", 8'd255);
      wait_change_done("f255_change");
      measure_period("f255_period", hi, lo);
      chk("f255_high", hi, 255);
      chk("f255_low", lo, 255);
`ifdef DIVSEQ_STATUS_EN
      chk("status_cur_div", int'(cur_div), 255);
      chk("status_reconfig_cnt", int'(reconfig_cnt), 2);
`endif

      run = 1'b0;
      repeat (600) @(posedge clk);
      #1;
      chk("end_div_clk", int'(div_clk), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
